// File: rtl/edge_pulse_pkg.sv
// rtl/edge_pulse_pkg.sv - mode encodings and counter-width helper
//
// Purpose : shared definitions for the edge pulse generator.
// Contents: MODE_RISE/MODE_FALL/MODE_BOTH/MODE_OFF encodings of the 2-bit
//           mode input, and cnt_w(n), the width of a counter that must hold
//           0..n-1 (at least 1 bit).
package edge_pulse_pkg;

   localparam logic [1:0] MODE_RISE = 2'b00;
   localparam logic [1:0] MODE_FALL = 2'b01;
   localparam logic [1:0] MODE_BOTH = 2'b10;
   localparam logic [1:0] MODE_OFF  = 2'b11;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/edge_pulse_channel.sv
// rtl/edge_pulse_channel.sv - one channel: sync, debounce, edge decode, repeat
//
// Purpose : synchronises one asynchronous input, debounces it into a level,
//           and emits a registered one-clock pulse on the edge(s) selected
//           by mode. With EDGE_PULSE_REPEAT_EN defined, a held rise also
//           produces auto-repeat pulses.
// Ports   : clk   - clock, all logic on rising edge
//           reset - synchronous active-high reset
//           src   - raw asynchronous input
//           mode  - 00 rise, 01 fall, 10 both, 11 disabled
//           pulse - registered one-clock pulse
//           level - registered debounced level
// Macro   : EDGE_PULSE_REPEAT_EN enables the repeat counter and the
//           REPEAT_DELAY/REPEAT_PERIOD parameters.
module edge_pulse_channel
   import edge_pulse_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
`ifdef EDGE_PULSE_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 1000,
   parameter int REPEAT_PERIOD   = 200
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       src,
   input  logic [1:0] mode,
   output logic       pulse,
   output logic       level
);

   localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   level_q;
   logic                   pulse_q;
   logic                   s;
   logic                   differ;
   logic                   toggle;
   logic                   rise_en;
   logic                   fall_en;
   logic                   edge_hit;
   logic                   rep_hit;

   assign s      = sync_q[SYNC_STAGES-1];
   assign differ = s ^ level_q;
   // Terminal count while still different: level flips on this edge.
   assign toggle = differ && (cnt_q == CNT_LAST);

   always_comb begin
      rise_en = 1'b0;
      fall_en = 1'b0;
      case (mode)
         MODE_RISE: rise_en = 1'b1;
         MODE_FALL: fall_en = 1'b1;
         MODE_BOTH: begin
            rise_en = 1'b1;
            fall_en = 1'b1;
         end
         MODE_OFF: begin
            rise_en = 1'b0;
            fall_en = 1'b0;
         end
      endcase
   end

   // Toggle direction follows the current level: 0->1 is a rise.
   assign edge_hit = toggle && (level_q ? fall_en : rise_en);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], src};
         if (!differ) begin
            cnt_q <= '0;
         end else if (toggle) begin
            cnt_q   <= '0;
            level_q <= ~level_q;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
         pulse_q <= edge_hit | rep_hit;
      end
   end

`ifdef EDGE_PULSE_REPEAT_EN
   localparam int            RW         = cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [RW-1:0] REP_D_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] REP_P_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep_cnt_q;
   logic          rep_first_q;
   logic          rep_due;

   // rep_cnt_q counts edges since the last pulse of this held press; the
   // first gap uses the delay, later gaps the period. The edge on which
   // level falls never repeats.
   assign rep_due = level_q && !toggle &&
                    (rep_cnt_q == (rep_first_q ? REP_D_LAST : REP_P_LAST));
   assign rep_hit = rep_due && rise_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b0;
      end else if (toggle) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b1;
      end else if (!level_q) begin
         rep_cnt_q <= '0;
      end else if (rep_due) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_q + RW'(1);
      end
   end
`else
   assign rep_hit = 1'b0;
`endif

   assign pulse = pulse_q;
   assign level = level_q;

endmodule

// File: rtl/edge_pulse_gen_multi.sv
// rtl/edge_pulse_gen_multi.sv - multi-channel debounced edge pulse generator
//
// Purpose : CHANNELS independent edge_pulse_channel instances sharing one
//           clock, reset and mode; outputs are concatenated per channel.
// Ports   : clk   - clock, all logic on rising edge
//           reset - synchronous active-high reset
//           src   - CHANNELS raw asynchronous inputs
//           mode  - 00 rise, 01 fall, 10 both, 11 disabled (shared)
//           pulse - CHANNELS registered one-clock edge pulses
//           level - CHANNELS registered debounced levels
// Macro   : EDGE_PULSE_REPEAT_EN adds auto-repeat and the REPEAT_DELAY /
//           REPEAT_PERIOD parameters.
module edge_pulse_gen_multi
   import edge_pulse_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
`ifdef EDGE_PULSE_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 1000,
   parameter int REPEAT_PERIOD   = 200
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] src,
   input  logic [1:0]          mode,
   output logic [CHANNELS-1:0] pulse,
   output logic [CHANNELS-1:0] level
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      edge_pulse_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef EDGE_PULSE_REPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .src   (src[i]),
         .mode  (mode),
         .pulse (pulse[i]),
         .level (level[i])
      );
   end

endmodule

// File: tb/tb_edge_pulse_gen_multi.sv
// tb/tb_edge_pulse_gen_multi.sv - directed self-checking bench for edge_pulse_gen_multi
module tb_edge_pulse_gen_multi;
   import edge_pulse_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] src;
   logic [1:0] mode;
   logic [3:0] pulse;
   logic [3:0] level;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   edge_pulse_gen_multi #(
      .CHANNELS        (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
`ifdef EDGE_PULSE_REPEAT_EN
      ,
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .src   (src),
      .mode  (mode),
      .pulse (pulse),
      .level (level)
   );

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge; outputs are settled and inputs may change.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [63:0] at(input int e);
      logic [63:0] one;
      one = 64'd1;
      return one << e;
   endfunction

   // Step n edges; pulse must equal m on every edge k with hits[k] set, else 0.
   task automatic expect_pulses(input string tag, input int n,
                                input logic [63:0] hits, input logic [3:0] m);
      for (int k = 1; k <= n; k++) begin
         step();
         chk(tag, pulse, hits[k] ? m : 4'h0);
      end
   endtask

   initial begin
      // 1. src high through reset, fresh rise after release
      reset = 1'b1;
      src   = 4'hF;
      mode  = MODE_RISE;
      step();
      chk("rst_pulse0", pulse, 4'h0);
      chk("rst_level0", level, 4'h0);
      step();
      chk("rst_pulse1", pulse, 4'h0);
      chk("rst_level1", level, 4'h0);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("rel_pulse", pulse, (k == 6) ? 4'hF : 4'h0);
         chk("rel_level", level, (k >= 6) ? 4'hF : 4'h0);
      end

      // all fall under mode rise: no pulses, levels drop
      src = 4'h0;
      expect_pulses("fall_all", 10, 64'd0, 4'h0);
      chk("fall_all_lvl", level, 4'h0);

      // 2. glitch of 3 cycles on channel 0
      src = 4'h1;
      step(); step(); step();
      chk("glitch_p", pulse, 4'h0);
      src = 4'h0;
      expect_pulses("glitch", 10, 64'd0, 4'h0);
      chk("glitch_lvl", level, 4'h0);

      // 3. rise on channel 1, single pulse, silent fall
      src = 4'h2;
      expect_pulses("rise1", 20, at(6), 4'h2);
      chk("rise1_lvl", level, 4'h2);
      src = 4'h0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("fall1_p", pulse, 4'h0);
         chk("fall1_lvl", level, (k >= 6) ? 4'h0 : 4'h2);
      end

      // 4. both edges on channel 2, then disabled
      mode = MODE_BOTH;
      src  = 4'h4;
      expect_pulses("both_r", 10, at(6), 4'h4);
      src = 4'h0;
      expect_pulses("both_f", 10, at(6), 4'h4);
      chk("both_lvl", level, 4'h0);
      mode = MODE_OFF;
      src  = 4'h4;
      expect_pulses("off_r", 10, 64'd0, 4'h0);
      chk("off_lvl_hi", level, 4'h4);
      src = 4'h0;
      expect_pulses("off_f", 10, 64'd0, 4'h0);
      chk("off_lvl_lo", level, 4'h0);

      // 5. reset mid-debounce on channel 3
      mode = MODE_RISE;
      src  = 4'h8;
      expect_pulses("pre_rst", 3, 64'd0, 4'h0);
      reset = 1'b1;
      step();
      chk("mid_rst_p", pulse, 4'h0);
      chk("mid_rst_l", level, 4'h0);
      reset = 1'b0;
      expect_pulses("post_rst", 8, at(6), 4'h8);
      chk("post_rst_lvl", level, 4'h8);
      src = 4'h0;
      expect_pulses("settle", 10, 64'd0, 4'h0);
      chk("settle_lvl", level, 4'h0);

`ifdef EDGE_PULSE_REPEAT_EN
      // 6. auto-repeat: accept at edge 6, repeats every 10 then 5 edges
      src = 4'h1;
      expect_pulses("rep_on", 36, at(6) | at(16) | at(21) | at(26) | at(31) | at(36), 4'h1);
      chk("rep_on_lvl", level, 4'h1);
      src = 4'h0;
      // edge 41 overall still repeats; level falls at 42, nothing after
      expect_pulses("rep_off", 20, at(5), 4'h1);
      chk("rep_off_lvl", level, 4'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
